alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execute-stage ALU that consumes the 4-bit `ALUCtl` code from the ALU control decoder together with the two operands, and returns a registered result through a valid/ready handshake. Add/sub, logic and compare ops complete in one cycle. Shifts run iteratively, one bit position per cycle, to keep area down. Sits between the ID/EX operand path and the EX/MEM result register; the `zero` output feeds branch resolution.

## Interface
- `XLEN`, 32, operand and result width.
- `SHAMT_W`, 5, shift-amount width; the amount is taken from `b[SHAMT_W-1:0]`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: operands and `alu_ctl` are valid this cycle.
- `in_ready` out 1: unit can accept an operation.
- `alu_ctl` in 4: operation code; uses the `ALU_*` codes from `definitions.svh`.
- `a` in XLEN: operand A (rs1).
- `b` in XLEN: operand B (rs2 or immediate).
- `out_valid` out 1: `result` and `zero` are valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out XLEN: registered ALU result.
- `zero` out 1: registered `(result == 0)`.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE.** `in_ready` = 1. On `in_valid`, the unit latches the operation.
  - Shift codes (`ALU_SLL`/`SLLI`, `ALU_SRL`/`SRLI`, `ALU_SRA`/`SRAI`):
    - load the shift register with `a` and the counter with `b[SHAMT_W-1:0]`;
    - go to SHIFT if the count is nonzero, else go straight to DONE with `result = a`.
  - All other codes: compute the result, register it, go to DONE.
- **SHIFT.** Each cycle the unit shifts by 1 and decrements the counter. When the counter reaches 0 after the shift, it goes to DONE.
  - SRA shifts in the sign bit `a[XLEN-1]`.
  - SLL and SRL shift in 0.
- **DONE.** `out_valid` = 1. `result` and `zero` are held stable until `out_ready`. On `out_valid && out_ready`, the unit returns to IDLE.
- `in_ready` = 1 only in IDLE. There is no overlap of accept and drain.
- Arithmetic, modulo 2^XLEN; carries are discarded:
  - `ALU_ADD`/`ALU_ADDI`: `a+b`.
  - `ALU_SUB`: `a-b`, which also serves BEQ via `zero`.
  - `ALU_AND`/`ANDI`, `ALU_OR`/`ORI`, `ALU_XOR`/`XORI`: bitwise.
- Compare codes write a 0/1 result zero-extended to XLEN:
  - `ALU_SLT`/`SLTI`: `a<b` signed.
  - `ALU_SLTU`/`SLTIU`: `a<b` unsigned.
  - `ALU_SB_BNE`: `a!=b`.
  - `ALU_SB_BGE`: `a>=b` signed.
  - `ALU_SB_BGEU`: `a>=b` unsigned.
- Immediate variants behave identically to their register forms; operand B already carries the immediate.
- `4'b1111` or any unlisted code: `result = 0`, `zero = 1`, one-cycle path. This covers JAL/JALR.
- The shift amount uses only `b[SHAMT_W-1:0]`; upper bits of `b` are ignored.

## Timing
- Reset values: `in_ready` = 1 from the first cycle after reset; `out_valid` = 0; `result` = 0; `zero` = 1; FSM in IDLE; counter = 0.
- Latency is counted from the accept edge (`in_valid && in_ready`) to the first cycle with `out_valid` = 1:
  - non-shift ops and shift-by-0: 1 cycle;
  - shift by n (1..31): 1+n cycles.
- Minimum issue interval is 2 cycles: accept, then DONE with `out_ready` = 1.
- Output stalls: `out_valid` stays high and `result` stays unchanged for any number of cycles with `out_ready` = 0.
- Inputs may change freely after the accept edge; operands are captured internally.
- `in_valid` while busy (SHIFT or DONE): ignored. The upstream stage holds it until `in_ready`.
- `reset` asserted in any state: the next edge returns to IDLE with reset values. An in-flight operation is discarded, and no `out_valid` pulse is produced for it.
- `out_ready` high while `out_valid` is low: no effect.

## Test plan
- Reset, then ADD with a=0x7FFFFFFF, b=1 → one cycle later `out_valid`, `result`=0x80000000, `zero`=0. With `out_ready` held low for 3 cycles, the outputs stay stable.
- SUB with a=b=0x1234 → `result`=0, `zero`=1. SB_BNE with a=5, b=6 → `result`=1. SB_BGEU with a=1, b=0xFFFFFFFF → `result`=0. SLT with a=0xFFFFFFFF, b=1 → `result`=1.
- SRA with a=0x80000000, b=0x3F (shamt 31) → `out_valid` 32 cycles after accept, `result`=0xFFFFFFFF. SRL with the same operands → `result`=1. Check that `in_ready`=0 throughout.
- SLL with a=0xA5, b=0 → latency 1, `result`=0xA5. SLLI with a=1, b=4 → latency 5, `result`=0x10.
- `alu_ctl`=4'b1111 with a=0xDEAD, b=0xBEEF → `result`=0, `zero`=1, latency 1. Back-to-back ops with `out_ready`=1 → accepts exactly every 2 cycles.
- Assert `reset` 3 cycles into a shift by 10 → next cycle `in_ready`=1 and `out_valid`=0, with no stale result. A subsequent XOR with a=0xF0, b=0xFF → `result`=0x0F.

Source files
------------

// File: rtl/alu_exec_if.sv
// alu_exec_if: valid/ready operand and result bundle for the execute-stage ALU.
//   in_valid/in_ready : operation handshake (upstream -> ALU)
//   alu_ctl, a, b     : operation code and operands
//   out_valid/out_ready : result handshake (ALU -> downstream)
//   result, zero      : registered result and (result == 0)
// master = upstream/downstream side, slave = the ALU.
interface alu_exec_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctl;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output in_valid, alu_ctl, a, b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_ctl, a, b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with a registered result behind a
// valid/ready handshake. Add/sub, logic, compare and unknown codes finish in
// one cycle; shifts iterate one bit position per cycle.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous, active-high
//   bus   : alu_exec_if.slave (in_valid/in_ready, alu_ctl, a, b,
//           out_valid/out_ready, result, zero)
module alu_exec_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input logic       clk,
  input logic       reset,
  alu_exec_if.slave bus
);

  // ALU control codes; immediate forms share the register-form encoding.
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_XOR     = 4'b0011;
  localparam logic [3:0] ALU_SLL     = 4'b0100;
  localparam logic [3:0] ALU_SRL     = 4'b0101;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_SLTU    = 4'b1000;
  localparam logic [3:0] ALU_SRA     = 4'b1001;
  localparam logic [3:0] ALU_SB_BNE  = 4'b1010;
  localparam logic [3:0] ALU_SB_BGE  = 4'b1011;
  localparam logic [3:0] ALU_SB_BGEU = 4'b1100;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shop_t;

  state_t              state, state_d;
  shop_t               shop;
  logic [SHAMT_W-1:0]  cnt;
  logic [XLEN-1:0]     result_q;
  logic                zero_q;

  logic [XLEN-1:0]     alu_res;
  logic [XLEN-1:0]     shifted;
  logic                is_shift;
  logic                lt_s, lt_u;
  logic [SHAMT_W-1:0]  shamt;

  assign shamt = bus.b[SHAMT_W-1:0];
  assign lt_s  = $signed(bus.a) < $signed(bus.b);
  assign lt_u  = bus.a < bus.b;

  assign is_shift = (bus.alu_ctl == ALU_SLL) || (bus.alu_ctl == ALU_SRL) ||
                    (bus.alu_ctl == ALU_SRA);

  // Single-cycle datapath; unlisted codes (incl. 4'b1111) yield zero.
  always_comb begin
    alu_res = '0;
    case (bus.alu_ctl)
      ALU_ADD:     alu_res = bus.a + bus.b;
      ALU_SUB:     alu_res = bus.a - bus.b;
      ALU_AND:     alu_res = bus.a & bus.b;
      ALU_OR:      alu_res = bus.a | bus.b;
      ALU_XOR:     alu_res = bus.a ^ bus.b;
      ALU_SLT:     alu_res[0] = lt_s;
      ALU_SLTU:    alu_res[0] = lt_u;
      ALU_SB_BNE:  alu_res[0] = (bus.a != bus.b);
      ALU_SB_BGE:  alu_res[0] = ~lt_s;
      ALU_SB_BGEU: alu_res[0] = ~lt_u;
      default:     alu_res = '0;
    endcase
  end

  // The result register doubles as the shift register. Keeping the MSB on a
  // right-arithmetic step replicates the original sign bit a[XLEN-1].
  always_comb begin
    shifted = '0;
    case (shop)
      SH_LL:   shifted = {result_q[XLEN-2:0], 1'b0};
      SH_RL:   shifted = {1'b0, result_q[XLEN-1:1]};
      default: shifted = {result_q[XLEN-1], result_q[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (is_shift && (shamt != '0)) state_d = SHIFT;
          else                           state_d = DONE;
        end
      end
      SHIFT: if (cnt == SHAMT_W'(1)) state_d = DONE;
      DONE:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      cnt      <= '0;
      shop     <= SH_LL;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_shift) begin
              result_q <= bus.a;
              zero_q   <= (bus.a == '0);
              cnt      <= shamt;
              case (bus.alu_ctl)
                ALU_SLL: shop <= SH_LL;
                ALU_SRL: shop <= SH_RL;
                default: shop <= SH_RA;
              endcase
            end else begin
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
            end
          end
        end
        SHIFT: begin
          result_q <= shifted;
          zero_q   <= (shifted == '0);
          cnt      <= cnt - SHAMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_SLL  = 4'b0100;
  localparam logic [3:0] C_SRL  = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLTU = 4'b1000;
  localparam logic [3:0] C_SRA  = 4'b1001;
  localparam logic [3:0] C_BNE  = 4'b1010;
  localparam logic [3:0] C_BGE  = 4'b1011;
  localparam logic [3:0] C_BGEU = 4'b1100;
  localparam logic [3:0] C_NONE = 4'b1111;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_exec_if #(.XLEN(32)) bus ();

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure latency, check result/zero, optionally stall the
  // output for 'hold' cycles, then drain.
  task automatic run_op(input string tag, input logic [3:0] ctl,
                        input logic [31:0] oa, input logic [31:0] ob,
                        input logic [31:0] exp_r, input logic exp_z,
                        input int exp_lat, input int hold);
    int lat;
    logic busy_ok;
    logic [31:0] r0;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.alu_ctl   = ctl;
    bus.a         = oa;
    bus.b         = ob;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.alu_ctl   = 4'($urandom);
    bus.a         = $urandom;
    bus.b         = $urandom;
    // out_ready high while nothing is valid must be harmless
    bus.out_ready = (hold == 0);
    lat = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bus.in_ready) busy_ok = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_result"}, bus.result, exp_r);
    check({tag, "_zero"}, 32'(bus.zero), 32'(exp_z));
    r0 = bus.result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_result"}, bus.result, r0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int accepts;
    int lat;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_ctl   = '0;
    bus.a         = '0;
    bus.b         = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd1);

    run_op("add_ovf", C_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1, 3);
    run_op("sub_eq",  C_SUB, 32'h1234, 32'h1234, 32'd0, 1'b1, 1, 0);
    run_op("bne",     C_BNE, 32'd5, 32'd6, 32'd1, 1'b0, 1, 0);
    run_op("bgeu",    C_BGEU, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 0);
    run_op("slt",     C_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 0);
    run_op("sltu",    C_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1, 0);
    run_op("bge",     C_BGE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 1'b0, 1, 0);
    run_op("and",     C_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1, 0);
    run_op("or",      C_OR, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 1'b0, 1, 0);
    run_op("sra31",   C_SRA, 32'h8000_0000, 32'h3F, 32'hFFFF_FFFF, 1'b0, 32, 0);
    run_op("srl31",   C_SRL, 32'h8000_0000, 32'h3F, 32'd1, 1'b0, 32, 2);
    run_op("sll0",    C_SLL, 32'hA5, 32'd0, 32'hA5, 1'b0, 1, 0);
    run_op("slli4",   C_SLL, 32'd1, 32'd4, 32'h10, 1'b0, 5, 0);
    run_op("sra_up",  C_SRA, 32'h8000_0010, 32'hFFFF_FFE2, 32'hE000_0004, 1'b0, 3, 0);
    run_op("sll_out", C_SLL, 32'h8000_0000, 32'd1, 32'd0, 1'b1, 2, 0);
    run_op("none",    C_NONE, 32'hDEAD, 32'hBEEF, 32'd0, 1'b1, 1, 0);

    // Back-to-back: in_valid and out_ready held high for 10 cycles.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.alu_ctl   = C_ADD;
    bus.a         = 32'd3;
    bus.b         = 32'd4;
    bus.out_ready = 1'b1;
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.in_ready) accepts++;
      else check("b2b_result", bus.result, 32'd7);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'd5);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("b2b_idle", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of a 10-step shift.
    bus.in_valid = 1'b1;
    bus.alu_ctl  = C_SLL;
    bus.a        = 32'd1;
    bus.b        = 32'd10;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_result", bus.result, 32'd0);
    check("mid_rst_zero", 32'(bus.zero), 32'd1);
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid) lat++;
      @(negedge clk);
    end
    check("mid_rst_no_pulse", 32'(lat), 32'd0);
    run_op("xor_after_rst", C_XOR, 32'hF0, 32'hFF, 32'h0F, 1'b0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
